// File: rtl/cmp_pkg.sv
// Shared widths, FSM state codes and sizing helpers for the binary-search hash comparator.
package cmp_pkg;

  localparam int unsigned DEF_HASH_W     = 32;
  localparam int unsigned DEF_NUM_HASHES = 512;
  localparam int unsigned DEF_NUM_CH     = 2;
  localparam int unsigned DEF_TAG_W      = 16;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_PROBE = 3'd2;
  localparam state_t S_CMP   = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned width_of(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/bsearch_comparator_if.sv
// Config, request and result signals of the comparator; slave side is the comparator itself.
interface bsearch_comparator_if
  import cmp_pkg::*;
#(
  parameter int unsigned HASH_W     = DEF_HASH_W,
  parameter int unsigned NUM_HASHES = DEF_NUM_HASHES,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned TAG_W      = DEF_TAG_W
);

  localparam int unsigned IDX_W = clog2(NUM_HASHES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned CH_W  = width_of(NUM_CH);

  logic                     cfg_start;
  logic                     cfg_wr;
  logic [HASH_W-1:0]        cfg_din;
  logic                     cfg_end;
  logic                     cfg_ready;
  logic                     cfg_err;
  logic [CNT_W-1:0]         num_hashes;

  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH*HASH_W-1:0] in_hash;
  logic [NUM_CH*TAG_W-1:0]  in_tag;
  logic [NUM_CH-1:0]        in_ready;

  logic                     out_valid;
  logic                     out_ready;
  logic                     out_match;
  logic [IDX_W-1:0]         out_idx;
  logic [CH_W-1:0]          out_ch;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output cfg_start, cfg_wr, cfg_din, cfg_end, in_valid, in_hash, in_tag, out_ready,
    input  cfg_ready, cfg_err, num_hashes, in_ready,
    input  out_valid, out_match, out_idx, out_ch, out_tag
  );

  modport slave (
    input  cfg_start, cfg_wr, cfg_din, cfg_end, in_valid, in_hash, in_tag, out_ready,
    output cfg_ready, cfg_err, num_hashes, in_ready,
    output out_valid, out_match, out_idx, out_ch, out_tag
  );

endinterface

// File: rtl/cmp_rr_arb.sv
// One-hot round-robin arbiter: lowest requester at or after the pointer wins.
// The pointer only moves when the owner of a finished result is reported.
module cmp_rr_arb
  import cmp_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CH_W   = width_of(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              en_i,
  input  logic              upd_i,
  input  logic [CH_W-1:0]   upd_ch_i,
  output logic [NUM_CH-1:0] gnt_c_o,
  output logic [CH_W-1:0]   gnt_idx_c_o
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;

  // Pointer moves to the channel after the one just served.
  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) begin
      if (32'(upd_ch_i) + 32'd1 >= NUM_CH) ptr_d = '0;
      else                                 ptr_d = CH_W'(32'(upd_ch_i) + 32'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  // Scan channels in priority order starting at the pointer.
  always_comb begin
    logic            found;
    logic [CH_W-1:0] cand;
    gnt_c_o     = '0;
    gnt_idx_c_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(ptr_q) + i) % NUM_CH);
      if (en_i && !found && req_i[cand]) begin
        found         = 1'b1;
        gnt_c_o[cand] = 1'b1;
        gnt_idx_c_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bsearch_comparator.sv
// Sorted partial-hash table with binary-search lookup shared by NUM_CH requesters.
// Table loads must be strictly ascending; violations and overflow are dropped and flagged.
module bsearch_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned HASH_W     = DEF_HASH_W,
  parameter int unsigned NUM_HASHES = DEF_NUM_HASHES,
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned TAG_W      = DEF_TAG_W
) (
  input logic                clk,
  input logic                rst_n,
  bsearch_comparator_if.slave bus
);

  localparam int unsigned IDX_W = clog2(NUM_HASHES);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned CH_W  = width_of(NUM_CH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HASH_W-1:0] last_q, last_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  lo_q, lo_d;
  logic [CNT_W-1:0]  hi_q, hi_d;
  logic [HASH_W-1:0] key_q, key_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              match_q, match_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_ready_q, cfg_ready_d;

  logic [HASH_W-1:0] mem [NUM_HASHES];
  logic [HASH_W-1:0] ram_dout_q;

  logic              ram_we_c;
  logic [CNT_W-1:0]  mid_c;
  logic [CNT_W-1:0]  mid_inc_c;
  logic              arb_en_c;
  logic              arb_upd_c;
  logic [NUM_CH-1:0] gnt_c;
  logic [CH_W-1:0]   gnt_idx_c;

  // Half-open window [lo, hi); lo + hi < 2*NUM_HASHES always fits CNT_W.
  assign mid_c     = (lo_q + hi_q) >> 1;
  assign mid_inc_c = mid_c + CNT_W'(1);
  assign arb_en_c  = (state_q == S_IDLE) && !bus.cfg_start;

  cmp_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (bus.in_valid),
    .en_i        (arb_en_c),
    .upd_i       (arb_upd_c),
    .upd_ch_i    (ch_q),
    .gnt_c_o     (gnt_c),
    .gnt_idx_c_o (gnt_idx_c)
  );

  // Block RAM: write during load, one-cycle registered read on probe.
  always_ff @(posedge clk) begin
    if (ram_we_c) mem[cnt_q[IDX_W-1:0]] <= bus.cfg_din;
    if (state_q == S_PROBE) ram_dout_q <= mem[mid_c[IDX_W-1:0]];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    err_d       = err_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    key_d       = key_q;
    tag_d       = tag_q;
    ch_d        = ch_q;
    match_d     = match_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    ram_we_c    = 1'b0;
    arb_upd_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cfg_start) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end else if (|bus.in_valid) begin
          key_d   = bus.in_hash[32'(gnt_idx_c)*HASH_W +: HASH_W];
          tag_d   = bus.in_tag[32'(gnt_idx_c)*TAG_W +: TAG_W];
          ch_d    = gnt_idx_c;
          lo_d    = '0;
          hi_d    = cnt_q;
          match_d = 1'b0;
          idx_d   = '0;
          if (cnt_q == '0) begin
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_PROBE;
          end
        end
      end

      S_LOAD: begin
        if (bus.cfg_wr) begin
          if ((cnt_q < CNT_W'(NUM_HASHES)) && ((cnt_q == '0) || (bus.cfg_din > last_q))) begin
            ram_we_c = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            last_d   = bus.cfg_din;
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.cfg_end) state_d = S_IDLE;
      end

      S_PROBE: state_d = S_CMP;

      S_CMP: begin
        if (ram_dout_q == key_q) begin
          match_d     = 1'b1;
          idx_d       = IDX_W'(mid_c);
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end else if (ram_dout_q < key_q) begin
          lo_d = mid_inc_c;
          if (mid_inc_c == hi_q) begin
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_PROBE;
          end
        end else begin
          hi_d = mid_c;
          if (lo_q == mid_c) begin
            out_valid_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_PROBE;
          end
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          arb_upd_c   = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cfg_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      err_q       <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      key_q       <= '0;
      tag_q       <= '0;
      ch_q        <= '0;
      match_q     <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      err_q       <= err_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      key_q       <= key_d;
      tag_q       <= tag_d;
      ch_q        <= ch_d;
      match_q     <= match_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.cfg_err    = err_q;
  assign bus.num_hashes = cnt_q;
  assign bus.in_ready   = gnt_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_match  = match_q;
  assign bus.out_idx    = idx_q;
  assign bus.out_ch     = ch_q;
  assign bus.out_tag    = tag_q;

endmodule

// File: doc/bsearch_comparator.md
# bsearch_comparator

Parametrised successor to the per-salt hash comparator: stores up to NUM_HASHES partial hashes loaded from CMP_CONFIG in strictly ascending order and answers lookups by binary search instead of linear scan. Serves NUM_CH computing units through a round-robin arbiter and returns match/miss plus the hash number. Sits between the units' result outputs and the CMP_RESULT packet builder in the CORE_CLK domain.

## Interface
- HASH_W, 32: compared partial-hash width
- NUM_HASHES, 512: table depth; IDX_W = clog2(NUM_HASHES), CNT_W = IDX_W+1
- NUM_CH, 2: requesting channels
- TAG_W, 16: opaque per-request tag (word_id/pkt_id), passed through
- CLK  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- cfg_start  in  1  begin table load (honoured only when cfg_ready)
- cfg_wr  in  1  write cfg_din as next entry (LOAD only)
- cfg_din  in  HASH_W  entry value
- cfg_end  in  1  finish load
- cfg_ready  out  1  state==IDLE
- cfg_err  out  1  sticky: order violation or overflow in last load
- num_hashes  out  CNT_W  stored entry count
- in_valid  in  NUM_CH  per-channel request
- in_hash  in  NUM_CH*HASH_W  per-channel key, channel c at [c*HASH_W +: HASH_W]
- in_tag  in  NUM_CH*TAG_W  per-channel tag
- in_ready  out  NUM_CH  one-hot grant
- out_valid  out  1  result held until out_ready
- out_ready  in  1
- out_match  out  1
- out_idx  out  IDX_W  matched entry index (0 on miss)
- out_ch  out  clog2(NUM_CH)
- out_tag  out  TAG_W

## Operation
- States: IDLE, LOAD, PROBE, CMP, DONE.
- IDLE: cfg_start has priority over requests → clear cnt, clear cfg_err, go LOAD. Else if any in_valid: in_ready = RR grant (combinational from in_valid, zero when not IDLE or cfg_start high); latch key/tag/ch; lo=0, hi=cnt; go DONE (miss) if cnt==0, else PROBE.
- LOAD: cfg_wr accepted iff cnt<NUM_HASHES and (cnt==0 or cfg_din > last written); write ram[cnt], cnt++, last=cfg_din. Rejected write: entry dropped, cfg_err=1. cfg_wr and cfg_end same cycle: write first, then IDLE. cfg_start ignored in LOAD.
- PROBE: RAM address = mid = (lo+hi)>>1 (CNT_W arithmetic, half-open [lo,hi)); go CMP.
- CMP: ram_dout == key → match, out_idx=mid, DONE. ram_dout < key → lo=mid+1; else hi=mid. New lo==hi → miss, DONE; else PROBE. Unsigned compare.
- DONE: out_valid=1, outputs stable; on out_ready → IDLE, RR pointer = out_ch+1 mod NUM_CH.
- RR: lowest index at or after pointer among valid channels wins.
- Reset mid-search or mid-load: immediate return to IDLE; cnt=0, table contents irrelevant.

## Timing
- Reset values: cfg_ready=1, cfg_err=0, num_hashes=0, in_ready=0, out_valid=0, out_match=0, out_idx=0, out_ch=0, out_tag=0, RR pointer 0.
- RAM: synchronous read, 1-cycle latency (block RAM).
- Accept at edge t0; k probes → out_valid high from t0+2k+1; k ≤ clog2(cnt+1). cnt==0 → out_valid at t0+1.
- Next accept earliest the cycle after the out handshake.
- out_valid never drops without out_ready; outputs unchanged while stalled.

## Structure
- Package cmp_pkg: state enum, clog2 function, default widths.
- Sub-module cmp_rr_arb (NUM_CH one-hot round-robin arbiter with pointer update input).
- Table RAM inferred inline.

## Test plan
- Load 0x00000100..0x00000118, 0x04ab0d4f, 0xff000000..0xff000018 (51 entries); ch0 key 0x04ab0d4f tag 2 → match=1, idx=25, ch=0, tag=2, cfg_err=0, num_hashes=51.
- Same table, keys 0x00000100, 0xff000018, 0x04ab0d50 → idx 0 match, idx 50 match, miss; latencies ≤ 2*6+1 cycles.
- Empty table (cfg_start, cfg_end), key 0x93c527d7 → out_valid at t0+1, match=0.
- Load 0x10, 0x20, 0x20, 0x15, 0x30 → cfg_err=1, num_hashes=3, key 0x15 misses, 0x30 matches idx 2.
- NUM_HASHES=4, load 5 ascending values → cfg_err=1, num_hashes=4, fifth value misses.
- Both channels valid continuously, out_ready low 10 cycles per result → grants alternate ch0, ch1, ch0; outputs stable during stall; reset asserted mid-PROBE → out_valid=0, num_hashes=0 next cycle.
